// File: rtl/riscy_pkg.sv
// -----------------------------------------------------------------------------
// riscy_pkg
//   Types and constants shared by the RV64I decode stage and the execute ALU.
//   Contents:
//     XLEN           datapath width (64)
//     alu_op_e       ALU operation encoding
//     src1_e/src2_e  ALU operand selects
//     OPC_*          major opcode constants (instr[6:0])
//     dec_ctrl_t     decoded control bundle carried from decode to execute
//     funct3_to_op   OP / OP-IMM funct3 -> ALU operation
// -----------------------------------------------------------------------------
package riscy_pkg;

   localparam int XLEN = 64;

   typedef enum logic [4:0] {
      ALU_ADD_SUB = 5'd0,
      ALU_SLL     = 5'd4,
      ALU_XOR     = 5'd9,
      ALU_SRL_SRA = 5'd13,
      ALU_OR      = 5'd18,
      ALU_SLT     = 5'd22,
      ALU_AND     = 5'd27,
      ALU_SLTU    = 5'd31
   } alu_op_e;

   typedef enum logic [2:0] {
      SRC1_REG  = 3'd0,
      SRC1_ZERO = 3'd2,
      SRC1_PC   = 3'd5
   } src1_e;

   typedef enum logic [2:0] {
      SRC2_REG  = 3'd0,
      SRC2_FOUR = 3'd2,
      SRC2_IMM  = 3'd5
   } src2_e;

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;

   // An all-zero bundle is a harmless ADD REG,REG with no write.
   typedef struct packed {
      alu_op_e    alu_op;
      logic       sub_sra;
      src1_e      src1;
      src2_e      src2;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       branch;
      logic       jump;
      logic       branch_on_zero;
      logic       mem_read;
      logic       mem_write;
      logic       word;
      logic       illegal;
   } dec_ctrl_t;

   function automatic alu_op_e funct3_to_op(input logic [2:0] funct3);
      alu_op_e op;
      case (funct3)
         3'b000:  op = ALU_ADD_SUB;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = ALU_SRL_SRA;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// -----------------------------------------------------------------------------
// imm_gen
//   Combinational immediate extraction. The format is chosen from the major
//   opcode; every immediate is sign-extended from instr[31] to XLEN bits.
//   Opcodes without an immediate (OP, OP-32, unknown) yield zero.
//   Ports:
//     instr  in   32    raw instruction
//     imm    out  XLEN  sign-extended immediate
// -----------------------------------------------------------------------------
module imm_gen
   import riscy_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm
);

   always_comb begin
      imm = '0;
      case (instr[6:0])
         OPC_OP_IMM, OPC_OP_IMM_32, OPC_LOAD, OPC_JALR:
            imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
         OPC_STORE:
            imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
         OPC_BRANCH:
            imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                   instr[30:25], instr[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC:
            imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
         OPC_JAL:
            imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                   instr[20], instr[30:21], 1'b0};
         default:
            imm = '0;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   RV64I decode stage. One instruction + PC is accepted per valid/ready
//   handshake, decoded combinationally and captured into a single output slot.
//   Ports:
//     clk, rst_n                 clock (rising edge), async active-low reset
//     flush_in                   drop the held slot and any same-cycle input
//     in_valid / in_ready        upstream handshake (in_ready is combinational)
//     instr_in, pc_in            instruction word and its address
//     out_valid / out_ready      downstream handshake
//     pc_out                     captured pc_in
//     rs1_out, rs2_out, rd_out   register indices (rd_out = 0 when no write)
//     alu_op_out, sub_sra_out    ALU operation and subtract/arith-shift modifier
//     src1_out, src2_out         ALU operand selects
//     imm_out                    sign-extended immediate (0 for R-type)
//     branch_out, jump_out, branch_on_zero_out
//     mem_read_out, mem_write_out, word_out
//     illegal_out                undecodable; every other control reads as NOP
// -----------------------------------------------------------------------------
module decode_stage
   import riscy_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush_in,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr_in,
   input  logic [XLEN-1:0] pc_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] pc_out,
   output logic [4:0]      rs1_out,
   output logic [4:0]      rs2_out,
   output logic [4:0]      rd_out,
   output logic [4:0]      alu_op_out,
   output logic            sub_sra_out,
   output logic [2:0]      src1_out,
   output logic [2:0]      src2_out,
   output logic [XLEN-1:0] imm_out,
   output logic            branch_out,
   output logic            jump_out,
   output logic            branch_on_zero_out,
   output logic            mem_read_out,
   output logic            mem_write_out,
   output logic            word_out,
   output logic            illegal_out
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [XLEN-1:0] imm_raw;
   logic [XLEN-1:0] imm_dec;
   dec_ctrl_t       dec;
   logic            rd_we;
   logic            bad;
   logic            accept;

   logic            valid_reg;
   dec_ctrl_t       ctrl_reg;
   logic [XLEN-1:0] pc_reg;
   logic [XLEN-1:0] imm_reg;

   assign opcode = instr_in[6:0];
   assign funct3 = instr_in[14:12];
   assign funct7 = instr_in[31:25];

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr (instr_in),
      .imm   (imm_raw)
   );

   // ---------------------------------------------------------------------
   // Combinational decode
   // ---------------------------------------------------------------------
   always_comb begin
      dec        = '0;
      dec.alu_op = ALU_ADD_SUB;
      dec.src1   = SRC1_REG;
      dec.src2   = SRC2_REG;
      rd_we      = 1'b0;
      bad        = 1'b0;
      imm_dec    = imm_raw;

      case (opcode)
         OPC_LUI: begin
            dec.src1 = SRC1_ZERO;
            dec.src2 = SRC2_IMM;
            rd_we    = 1'b1;
         end
         OPC_AUIPC: begin
            dec.src1 = SRC1_PC;
            dec.src2 = SRC2_IMM;
            rd_we    = 1'b1;
         end
         // Both jumps compute the link value PC+4; the target adder is elsewhere.
         OPC_JAL, OPC_JALR: begin
            dec.src1 = SRC1_PC;
            dec.src2 = SRC2_FOUR;
            dec.jump = 1'b1;
            rd_we    = 1'b1;
         end
         OPC_LOAD: begin
            bad          = (funct3 == 3'b111);
            dec.src2     = SRC2_IMM;
            dec.mem_read = 1'b1;
            rd_we        = 1'b1;
         end
         OPC_STORE: begin
            bad           = funct3[2];
            dec.src2      = SRC2_IMM;
            dec.mem_write = 1'b1;
         end
         // Equality compares subtract and test for zero; ordered compares use
         // SLT/SLTU, where the "greater or equal" forms branch on a zero result.
         OPC_BRANCH: begin
            dec.branch = 1'b1;
            bad        = (funct3[2:1] == 2'b01);
            case (funct3[2:1])
               2'b00: begin
                  dec.alu_op  = ALU_ADD_SUB;
                  dec.sub_sra = 1'b1;
               end
               2'b10:   dec.alu_op = ALU_SLT;
               default: dec.alu_op = ALU_SLTU;
            endcase
            dec.branch_on_zero = (funct3 == 3'b000) || (funct3 == 3'b101) ||
                                 (funct3 == 3'b111);
         end
         // 6-bit shamt: instr[25] belongs to the shift amount.
         OPC_OP_IMM: begin
            dec.alu_op = funct3_to_op(funct3);
            dec.src2   = SRC2_IMM;
            rd_we      = 1'b1;
            if (funct3 == 3'b001) begin
               bad = (instr_in[31:26] != 6'b0);
            end else if (funct3 == 3'b101) begin
               bad         = instr_in[31] || (instr_in[29:26] != 4'b0);
               dec.sub_sra = instr_in[30];
            end
         end
         // 5-bit shamt: instr[25] must be clear.
         OPC_OP_IMM_32: begin
            dec.alu_op = funct3_to_op(funct3);
            dec.src2   = SRC2_IMM;
            dec.word   = 1'b1;
            rd_we      = 1'b1;
            case (funct3)
               3'b000: bad = 1'b0;
               3'b001: bad = (funct7 != 7'b0);
               3'b101: begin
                  bad         = ((funct7 & 7'b1011111) != 7'b0);
                  dec.sub_sra = instr_in[30];
               end
               default: bad = 1'b1;
            endcase
         end
         OPC_OP: begin
            dec.alu_op = funct3_to_op(funct3);
            rd_we      = 1'b1;
            if (funct3 == 3'b000 || funct3 == 3'b101) begin
               bad         = ((funct7 & 7'b1011111) != 7'b0);
               dec.sub_sra = instr_in[30];
            end else begin
               bad = (funct7 != 7'b0);
            end
            // R-type has no immediate field.
            imm_dec = '0;
         end
         OPC_OP_32: begin
            dec.alu_op = funct3_to_op(funct3);
            dec.word   = 1'b1;
            rd_we      = 1'b1;
            case (funct3)
               3'b000, 3'b101: begin
                  bad         = ((funct7 & 7'b1011111) != 7'b0);
                  dec.sub_sra = instr_in[30];
               end
               3'b001:  bad = (funct7 != 7'b0);
               default: bad = 1'b1;
            endcase
            imm_dec = '0;
         end
         default: bad = 1'b1;
      endcase

      dec.rs1 = instr_in[19:15];
      dec.rs2 = instr_in[24:20];
      dec.rd  = rd_we ? instr_in[11:7] : 5'd0;

      // Illegal words travel down the pipe as a NOP flagged for the trap logic.
      if (bad) begin
         dec         = '0;
         dec.illegal = 1'b1;
         imm_dec     = '0;
      end
   end

   // ---------------------------------------------------------------------
   // Output slot
   // ---------------------------------------------------------------------
   assign in_ready = !valid_reg || out_ready;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg <= 1'b0;
         ctrl_reg  <= '0;
         pc_reg    <= '0;
         imm_reg   <= '0;
      end else begin
         if (flush_in) begin
            valid_reg <= 1'b0;
         end else if (accept) begin
            valid_reg <= 1'b1;
         end else if (out_ready) begin
            valid_reg <= 1'b0;
         end
         // A flushed instruction is dropped, so the payload only moves on a
         // surviving accept; otherwise it holds for a stalled consumer.
         if (accept && !flush_in) begin
            ctrl_reg <= dec;
            pc_reg   <= pc_in;
            imm_reg  <= imm_dec;
         end
      end
   end

   assign out_valid          = valid_reg;
   assign pc_out             = pc_reg;
   assign imm_out            = imm_reg;
   assign rs1_out            = ctrl_reg.rs1;
   assign rs2_out            = ctrl_reg.rs2;
   assign rd_out             = ctrl_reg.rd;
   assign alu_op_out         = ctrl_reg.alu_op;
   assign sub_sra_out        = ctrl_reg.sub_sra;
   assign src1_out           = ctrl_reg.src1;
   assign src2_out           = ctrl_reg.src2;
   assign branch_out         = ctrl_reg.branch;
   assign jump_out           = ctrl_reg.jump;
   assign branch_on_zero_out = ctrl_reg.branch_on_zero;
   assign mem_read_out       = ctrl_reg.mem_read;
   assign mem_write_out      = ctrl_reg.mem_write;
   assign word_out           = ctrl_reg.word;
   assign illegal_out        = ctrl_reg.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//   Table of hand-decoded instructions, directed handshake sequences
//   (backpressure, flush, async reset) and a randomized run scored against an
//   instruction-level reference decoder and a one-slot handshake model.
// -----------------------------------------------------------------------------
module tb_decode_stage;

   typedef struct packed {
      logic [4:0]  op;
      logic        sub;
      logic [2:0]  s1;
      logic [2:0]  s2;
      logic [63:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        br;
      logic        jmp;
      logic        boz;
      logic        mr;
      logic        mw;
      logic        w;
      logic        ill;
   } exp_t;

   typedef struct packed {
      logic [31:0] instr;
      exp_t        e;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush_in;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr_in;
   logic [63:0] pc_in;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] pc_out;
   logic [4:0]  rs1_out, rs2_out, rd_out, alu_op_out;
   logic        sub_sra_out;
   logic [2:0]  src1_out, src2_out;
   logic [63:0] imm_out;
   logic        branch_out, jump_out, branch_on_zero_out;
   logic        mem_read_out, mem_write_out, word_out, illegal_out;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(64)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .flush_in           (flush_in),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .instr_in           (instr_in),
      .pc_in              (pc_in),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
      .pc_out             (pc_out),
      .rs1_out            (rs1_out),
      .rs2_out            (rs2_out),
      .rd_out             (rd_out),
      .alu_op_out         (alu_op_out),
      .sub_sra_out        (sub_sra_out),
      .src1_out           (src1_out),
      .src2_out           (src2_out),
      .imm_out            (imm_out),
      .branch_out         (branch_out),
      .jump_out           (jump_out),
      .branch_on_zero_out (branch_on_zero_out),
      .mem_read_out       (mem_read_out),
      .mem_write_out      (mem_write_out),
      .word_out           (word_out),
      .illegal_out        (illegal_out)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got t=%0t want completion", $time);
      $fatal(1, "watchdog");
   end

   function automatic exp_t mk(int op, int sub, int s1, int s2, logic [63:0] imm,
                               int rs1, int rs2, int rd, int br, int jmp, int boz,
                               int mr, int mw, int w, int ill);
      exp_t e;
      e.op = op[4:0];   e.sub = sub[0]; e.s1 = s1[2:0]; e.s2 = s2[2:0];
      e.imm = imm;      e.rs1 = rs1[4:0]; e.rs2 = rs2[4:0]; e.rd = rd[4:0];
      e.br = br[0];     e.jmp = jmp[0]; e.boz = boz[0];
      e.mr = mr[0];     e.mw = mw[0];   e.w = w[0];   e.ill = ill[0];
      return e;
   endfunction

   // Reference decoder: instruction class first, then that class's controls.
   function automatic exp_t ref_decode(logic [31:0] i);
      exp_t        e;
      int          op_of_f3 [8] = '{0, 4, 22, 31, 9, 13, 18, 27};
      int          f3 = int'(i[14:12]);
      int          f7 = int'(i[31:25]);
      int          hi6 = int'(i[31:26]);
      bit          ok = 1'b1;
      bit          wr = 1'b0;
      longint      imm_i = longint'($signed(i[31:20]));
      longint      imm_s = longint'($signed({i[31:25], i[11:7]}));
      longint      imm_b = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      longint      imm_u = longint'($signed({i[31:12], 12'h000}));
      longint      imm_j = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      e = '0;
      e.rs1 = i[19:15];
      e.rs2 = i[24:20];
      case (i[6:0])
         7'h37: begin e.s1 = 2; e.s2 = 5; e.imm = imm_u; wr = 1; end
         7'h17: begin e.s1 = 5; e.s2 = 5; e.imm = imm_u; wr = 1; end
         7'h6F: begin e.s1 = 5; e.s2 = 2; e.jmp = 1; e.imm = imm_j; wr = 1; end
         7'h67: begin e.s1 = 5; e.s2 = 2; e.jmp = 1; e.imm = imm_i; wr = 1; end
         7'h03: begin ok = (f3 != 7); e.s2 = 5; e.mr = 1; e.imm = imm_i; wr = 1; end
         7'h23: begin ok = (f3 < 4); e.s2 = 5; e.mw = 1; e.imm = imm_s; end
         7'h63: begin
            ok = !(f3 == 2 || f3 == 3);
            e.br = 1;
            e.imm = imm_b;
            if (f3 <= 1) begin e.op = 0; e.sub = 1; end
            else if (f3 <= 5) e.op = 22;
            else e.op = 31;
            e.boz = (f3 == 0 || f3 == 5 || f3 == 7);
         end
         7'h13: begin
            e.op = op_of_f3[f3][4:0]; e.s2 = 5; e.imm = imm_i; wr = 1;
            if (f3 == 1) ok = (hi6 == 0);
            if (f3 == 5) begin ok = (hi6 == 0 || hi6 == 16); e.sub = i[30]; end
         end
         7'h1B: begin
            e.op = op_of_f3[f3][4:0]; e.s2 = 5; e.imm = imm_i; e.w = 1; wr = 1;
            if (f3 == 1) ok = (f7 == 0);
            else if (f3 == 5) begin ok = (f7 == 0 || f7 == 32); e.sub = i[30]; end
            else ok = (f3 == 0);
         end
         7'h33: begin
            e.op = op_of_f3[f3][4:0]; wr = 1;
            ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
            if (f3 == 0 || f3 == 5) e.sub = i[30];
         end
         7'h3B: begin
            e.op = op_of_f3[f3][4:0]; e.w = 1; wr = 1;
            if (f3 == 0 || f3 == 5) begin ok = (f7 == 0 || f7 == 32); e.sub = i[30]; end
            else ok = (f3 == 1 && f7 == 0);
         end
         default: ok = 0;
      endcase
      if (wr) e.rd = i[11:7];
      if (!ok) begin
         e = '0;
         e.ill = 1;
      end
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0]  opcs [14] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63,
                                 7'h13, 7'h1B, 7'h33, 7'h3B, 7'h7F, 7'h0F, 7'h73};
      logic [31:0] i = $urandom;
      int          r = $urandom_range(0, 7);
      i[6:0] = opcs[$urandom_range(0, 13)];
      case (r)
         0, 1: i[31:25] = 7'h00;
         2, 3: i[31:25] = 7'h20;
         4:    i[31:25] = 7'h01;
         5:    i[31:25] = 7'h21;
         default: ;
      endcase
      return i;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
      end
   endtask

   task automatic chk_slot(input string tag, input exp_t e, input logic [63:0] pc);
      chk({tag, ".pc"},      pc_out,             pc);
      chk({tag, ".alu_op"},  64'(alu_op_out),    64'(e.op));
      chk({tag, ".sub_sra"}, 64'(sub_sra_out),   64'(e.sub));
      chk({tag, ".src1"},    64'(src1_out),      64'(e.s1));
      chk({tag, ".src2"},    64'(src2_out),      64'(e.s2));
      chk({tag, ".imm"},     imm_out,            e.imm);
      chk({tag, ".rs1"},     64'(rs1_out),       64'(e.rs1));
      chk({tag, ".rs2"},     64'(rs2_out),       64'(e.rs2));
      chk({tag, ".rd"},      64'(rd_out),        64'(e.rd));
      chk({tag, ".branch"},  64'(branch_out),    64'(e.br));
      chk({tag, ".jump"},    64'(jump_out),      64'(e.jmp));
      chk({tag, ".boz"},     64'(branch_on_zero_out), 64'(e.boz));
      chk({tag, ".mem_rd"},  64'(mem_read_out),  64'(e.mr));
      chk({tag, ".mem_wr"},  64'(mem_write_out), 64'(e.mw));
      chk({tag, ".word"},    64'(word_out),      64'(e.w));
      chk({tag, ".illegal"}, 64'(illegal_out),   64'(e.ill));
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                        input logic rdy, input logic fl);
      @(negedge clk);
      in_valid  = v;
      instr_in  = ins;
      pc_in     = pc;
      out_ready = rdy;
      flush_in  = fl;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b1; flush_in = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   vec_t  vecs [12];
   exp_t  e_auipc;
   exp_t  m_e;
   logic  m_valid;
   logic [63:0] m_pc;
   logic  acc;
   int    n_tx;

   initial begin
      rst_n = 1'b0; flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      instr_in = 32'h0; pc_in = 64'h0;

      //                          op  sub s1 s2 imm                     rs1 rs2 rd br j boz mr mw w ill
      vecs[0]  = '{32'hFFF10093, mk(0,  0, 0, 5, 64'hFFFF_FFFF_FFFF_FFFF, 2, 31, 1, 0, 0, 0, 0, 0, 0, 0)};
      vecs[1]  = '{32'h402081B3, mk(0,  1, 0, 0, 64'h0,                   1, 2,  3, 0, 0, 0, 0, 0, 0, 0)};
      vecs[2]  = '{32'h43F2D293, mk(13, 1, 0, 5, 64'h43F,                 5, 31, 5, 0, 0, 0, 0, 0, 0, 0)};
      vecs[3]  = '{32'hFE20DCE3, mk(22, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 1, 2,  0, 1, 0, 1, 0, 0, 0, 0)};
      vecs[4]  = '{32'h123450FF, mk(0,  0, 0, 0, 64'h0,                   0, 0,  0, 0, 0, 0, 0, 0, 0, 1)};
      vecs[5]  = '{32'h022081B3, mk(0,  0, 0, 0, 64'h0,                   0, 0,  0, 0, 0, 0, 0, 0, 0, 1)};
      vecs[6]  = '{32'h0103B303, mk(0,  0, 0, 5, 64'h10,                  7, 16, 6, 0, 0, 0, 1, 0, 0, 0)};
      vecs[7]  = '{32'h80000537, mk(0,  0, 2, 5, 64'hFFFF_FFFF_8000_0000, 0, 0, 10, 0, 0, 0, 0, 0, 0, 0)};
      vecs[8]  = '{32'h008000EF, mk(0,  0, 5, 2, 64'h8,                   0, 8,  1, 0, 1, 0, 0, 0, 0, 0)};
      vecs[9]  = '{32'hFE533E23, mk(0,  0, 0, 5, 64'hFFFF_FFFF_FFFF_FFFC, 6, 5,  0, 0, 0, 0, 0, 1, 0, 0)};
      vecs[10] = '{32'h02029293, mk(4,  0, 0, 5, 64'h20,                  5, 0,  5, 0, 0, 0, 0, 0, 0, 0)};
      vecs[11] = '{32'h0202929B, mk(0,  0, 0, 0, 64'h0,                   0, 0,  0, 0, 0, 0, 0, 0, 0, 1)};
      e_auipc  = mk(0, 0, 5, 5, 64'h1000, 0, 0, 10, 0, 0, 0, 0, 0, 0, 0);

      // ---------------- reset state ----------------
      do_reset();
      #1;
      chk("reset.out_valid", 64'(out_valid), 64'd0);
      chk("reset.in_ready",  64'(in_ready),  64'd1);
      chk_slot("reset", '0, 64'h0);

      // ---------------- table vectors ----------------
      for (int k = 0; k < 12; k++) begin
         drive(1'b1, vecs[k].instr, 64'h8000_0000 + 64'(k * 4), 1'b1, 1'b0);
         step();
         chk($sformatf("vec%0d.out_valid", k), 64'(out_valid), 64'd1);
         chk_slot($sformatf("vec%0d", k), vecs[k].e, 64'h8000_0000 + 64'(k * 4));
         $display("vec %0d instr=%08h alu_op=%0d imm=%h illegal=%0b", k, vecs[k].instr,
                  alu_op_out, imm_out, illegal_out);
      end
      drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      step();
      chk("drain.out_valid", 64'(out_valid), 64'd0);

      // ---------------- backpressure ----------------
      drive(1'b1, 32'h00001517, 64'h1000, 1'b0, 1'b0);
      step();
      chk("bp.accept.valid", 64'(out_valid), 64'd1);
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, vecs[0].instr, 64'h2000, 1'b0, 1'b0);
         #1;
         chk($sformatf("bp%0d.in_ready", c), 64'(in_ready), 64'd0);
         step();
         chk($sformatf("bp%0d.out_valid", c), 64'(out_valid), 64'd1);
         chk_slot($sformatf("bp%0d", c), e_auipc, 64'h1000);
      end
      $display("bp auipc held 3 cycles pc=%h", pc_out);
      drive(1'b1, vecs[0].instr, 64'h2000, 1'b1, 1'b0);
      #1;
      chk("bp.release.in_ready", 64'(in_ready), 64'd1);
      step();
      chk("bp.next.out_valid", 64'(out_valid), 64'd1);
      chk_slot("bp.next", vecs[0].e, 64'h2000);
      $display("bp next instr captured pc=%h", pc_out);

      // ---------------- flush ----------------
      drive(1'b1, vecs[1].instr, 64'h3000, 1'b1, 1'b0);
      step();
      drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
      step();
      chk("fl.held.valid", 64'(out_valid), 64'd1);
      drive(1'b1, vecs[0].instr, 64'h3004, 1'b1, 1'b1);
      step();
      chk("fl.out_valid", 64'(out_valid), 64'd0);
      chk("fl.not_captured.pc", pc_out, 64'h3000);
      drive(1'b1, vecs[2].instr, 64'h3008, 1'b1, 1'b0);
      step();
      chk("fl.after.valid", 64'(out_valid), 64'd1);
      chk_slot("fl.after", vecs[2].e, 64'h3008);
      $display("flush done, next pc=%h", pc_out);

      // ---------------- async reset mid-stall ----------------
      drive(1'b1, vecs[3].instr, 64'h4000, 1'b0, 1'b0);
      step();
      drive(1'b1, vecs[6].instr, 64'h4004, 1'b0, 1'b0);
      step();
      chk("ar.held.valid", 64'(out_valid), 64'd1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar.out_valid", 64'(out_valid), 64'd0);
      chk("ar.imm", imm_out, 64'h0);
      chk("ar.branch", 64'(branch_out), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b0;
      #1;
      chk("ar.release.in_ready", 64'(in_ready), 64'd1);
      $display("async reset mid-stall cleared slot");

      // ---------------- randomized run ----------------
      do_reset();
      m_valid = 1'b0;
      m_e = '0;
      m_pc = '0;
      n_tx = 0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         in_valid  = ($urandom_range(0, 3) != 0);
         instr_in  = rand_instr();
         pc_in     = {$urandom, $urandom};
         out_ready = ($urandom_range(0, 2) != 0);
         flush_in  = ($urandom_range(0, 15) == 0);
         #1;
         chk("rnd.in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
         @(posedge clk);
         acc = in_valid && (!m_valid || out_ready);
         if (flush_in) begin
            m_valid = 1'b0;
         end else if (acc) begin
            m_valid = 1'b1;
            m_e  = ref_decode(instr_in);
            m_pc = pc_in;
            n_tx++;
            $display("rnd tx %0d instr=%08h pc=%h illegal=%0b", n_tx, instr_in, pc_in, m_e.ill);
         end else if (out_ready) begin
            m_valid = 1'b0;
         end
         #1;
         chk("rnd.out_valid", 64'(out_valid), 64'(m_valid));
         if (m_valid) chk_slot("rnd", m_e, m_pc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
